pipeline_sequencer: RTL and testbench

Pipeline control sequencer for the 16-bit term-project processor. It sits beside the instruction decoder and drives the pipeline-register write enables and flushes. It sequences multi-cycle mul/div in EX, inserts load-use stalls, squashes wrong-path fetches on jump and taken branch, and drains the pipeline on halt.

---
 rtl/cpu_pkg.sv | 49 ++++
 rtl/stall_counter.sv | 29 ++
 rtl/pipeline_sequencer.sv | 142 ++++++++++++++
 tb/tb_pipeline_sequencer.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared opcode/funct constants, sequencer state encoding and the pipeline
// control bundle used by pipeline_sequencer.
package cpu_pkg;

    localparam int CNT_W = 5;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_BGT   = 4'b0101;
    localparam logic [3:0] OP_BLT   = 4'b0110;
    localparam logic [3:0] OP_LBU   = 4'b1000;
    localparam logic [3:0] OP_LW    = 4'b1010;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam logic [3:0] FN_MUL = 4'b0100;
    localparam logic [3:0] FN_DIV = 4'b1000;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_MULDIV = 2'b01,
        ST_DRAIN  = 2'b10,
        ST_HALTED = 2'b11
    } seq_state_t;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_write;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
        logic muldiv_start;
    } ctl_t;

    localparam ctl_t CTL_DEFAULT = '{pc_write: 1'b1, ifid_write: 1'b1, idex_write: 1'b1,
                                     ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0,
                                     muldiv_start: 1'b0};

    // Everything frozen and every stage bubbled; used by reset and HALTED.
    localparam ctl_t CTL_FREEZE  = '{pc_write: 1'b0, ifid_write: 1'b0, idex_write: 1'b0,
                                     ifid_flush: 1'b1, idex_flush: 1'b1, exmem_flush: 1'b1,
                                     muldiv_start: 1'b0};

    function automatic logic is_muldiv(input logic [3:0] opcode, input logic [3:0] funct);
        return (opcode == OP_RTYPE) && ((funct == FN_MUL) || (funct == FN_DIV));
    endfunction

endpackage

// File: rtl/stall_counter.sv
// Loadable down-counter shared by the MULDIV and DRAIN sequences; it saturates
// at 1 so the state machine can hold on is_one without re-arming.
module stall_counter
    import cpu_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         is_one
);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt > W'(1))) begin
            cnt <= cnt - W'(1);
        end
    end

    assign is_one = (cnt == W'(1));

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline control sequencer: multi-cycle mul/div stalls, load-use bubbles,
// wrong-path squash on branch/jump, and drain-then-stop on halt.
module pipeline_sequencer
    import cpu_pkg::*;
#(
    parameter int MUL_CYCLES   = 4,
    parameter int DIV_CYCLES   = 16,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] id_opcode,
    input  logic [3:0] id_rs,
    input  logic [3:0] id_rt,
    input  logic [3:0] ex_opcode,
    input  logic [3:0] ex_funct,
    input  logic [3:0] ex_rd,
    input  logic       ex_branch_taken,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       idex_write,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       exmem_flush,
    output logic       muldiv_start,
    output logic       muldiv_busy,
    output logic       halted,
    output logic [1:0] state
);

    localparam logic [CNT_W-1:0] MUL_LOAD   = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD   = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);

    seq_state_t       cur_state, next_state;
    ctl_t             ctl;
    logic             cnt_load, cnt_dec, cnt_is_one;
    logic [CNT_W-1:0] cnt_load_val, cnt;
    logic             busy, stop, load_use;

    stall_counter #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .is_one   (cnt_is_one)
    );

    always_ff @(posedge clk) begin
        if (reset) cur_state <= ST_RUN;
        else       cur_state <= next_state;
    end

    // Jump and halt in ID never consume the loaded value, so no bubble for them.
    assign load_use = ((ex_opcode == OP_LW) || (ex_opcode == OP_LBU)) &&
                      ((ex_rd == id_rs) || (ex_rd == id_rt)) &&
                      (id_opcode != OP_JMP) && (id_opcode != OP_HALT);

    always_comb begin
        ctl          = CTL_DEFAULT;
        next_state   = cur_state;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        busy         = 1'b0;
        stop         = 1'b0;
        if (reset) begin
            ctl        = CTL_FREEZE;
            next_state = ST_RUN;
        end else begin
            unique case (cur_state)
                ST_RUN: begin
                    if (ex_branch_taken) begin
                        ctl.ifid_flush = 1'b1;
                        ctl.idex_flush = 1'b1;
                    end else if (is_muldiv(ex_opcode, ex_funct)) begin
                        ctl.muldiv_start = 1'b1;
                        ctl.pc_write     = 1'b0;
                        ctl.ifid_write   = 1'b0;
                        ctl.idex_write   = 1'b0;
                        ctl.exmem_flush  = 1'b1;
                        cnt_load         = 1'b1;
                        cnt_load_val     = (ex_funct == FN_MUL) ? MUL_LOAD : DIV_LOAD;
                        next_state       = ST_MULDIV;
                    end else if (load_use) begin
                        ctl.pc_write   = 1'b0;
                        ctl.ifid_write = 1'b0;
                        ctl.idex_flush = 1'b1;
                    end else if (id_opcode == OP_HALT) begin
                        ctl.pc_write   = 1'b0;
                        ctl.ifid_write = 1'b0;
                        ctl.idex_flush = 1'b1;
                        cnt_load       = 1'b1;
                        cnt_load_val   = DRAIN_LOAD;
                        next_state     = ST_DRAIN;
                    end else if (id_opcode == OP_JMP) begin
                        ctl.ifid_flush = 1'b1;
                    end
                end
                ST_MULDIV: begin
                    busy = 1'b1;
                    // On the last count the defaults let the result advance out of EX.
                    if (cnt_is_one) begin
                        next_state = ST_RUN;
                    end else begin
                        ctl.pc_write    = 1'b0;
                        ctl.ifid_write  = 1'b0;
                        ctl.idex_write  = 1'b0;
                        ctl.exmem_flush = 1'b1;
                        cnt_dec         = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    ctl.pc_write   = 1'b0;
                    ctl.ifid_write = 1'b0;
                    ctl.idex_flush = 1'b1;
                    cnt_dec        = 1'b1;
                    if (cnt_is_one) next_state = ST_HALTED;
                end
                ST_HALTED: begin
                    ctl  = CTL_FREEZE;
                    stop = 1'b1;
                end
                default: next_state = ST_RUN;
            endcase
        end
    end

    assign pc_write     = ctl.pc_write;
    assign ifid_write   = ctl.ifid_write;
    assign idex_write   = ctl.idex_write;
    assign ifid_flush   = ctl.ifid_flush;
    assign idex_flush   = ctl.idex_flush;
    assign exmem_flush  = ctl.exmem_flush;
    assign muldiv_start = ctl.muldiv_start;
    assign muldiv_busy  = busy;
    assign halted       = stop;
    assign state        = cur_state;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: each step drives inputs just after a
// rising edge and checks the Mealy outputs on the following falling edge.
module tb_pipeline_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] id_opcode, id_rs, id_rt, ex_opcode, ex_funct, ex_rd;
    logic       ex_branch_taken;
    logic       pc_write, ifid_write, idex_write, ifid_flush, idex_flush, exmem_flush;
    logic       muldiv_start, muldiv_busy, halted;
    logic [1:0] state;

    int n_cmp = 0;
    int n_err = 0;

    // Control vector: {pc,ifid,idex write}_{ifid,idex,exmem flush}_{start,busy,halted}
    localparam logic [8:0] C_RST  = 9'b000_111_000;
    localparam logic [8:0] C_DEF  = 9'b111_000_000;
    localparam logic [8:0] C_BR   = 9'b111_110_000;
    localparam logic [8:0] C_JMP  = 9'b111_100_000;
    localparam logic [8:0] C_MDS  = 9'b000_001_100;
    localparam logic [8:0] C_MDB  = 9'b000_001_010;
    localparam logic [8:0] C_REL  = 9'b111_000_010;
    localparam logic [8:0] C_BUB  = 9'b001_010_000;
    localparam logic [8:0] C_HALT = 9'b000_111_001;

    pipeline_sequencer #(.MUL_CYCLES(4), .DIV_CYCLES(16), .DRAIN_CYCLES(3)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_opcode       (id_opcode),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .ex_opcode       (ex_opcode),
        .ex_funct        (ex_funct),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .idex_write      (idex_write),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .exmem_flush     (exmem_flush),
        .muldiv_start    (muldiv_start),
        .muldiv_busy     (muldiv_busy),
        .halted          (halted),
        .state           (state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] id_op, input logic [3:0] rs, input logic [3:0] rt,
                         input logic [3:0] ex_op, input logic [3:0] fn, input logic [3:0] rd,
                         input logic br);
        id_opcode = id_op; id_rs = rs; id_rt = rt;
        ex_opcode = ex_op; ex_funct = fn; ex_rd = rd; ex_branch_taken = br;
    endtask

    task automatic nop();
        drive(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    endtask

    // Checks outputs on the falling edge; state is skipped when chk_st is 0.
    task automatic check(input string tag, input int idx, input logic [8:0] exp_ctl,
                         input logic [1:0] exp_st, input bit chk_st);
        logic [8:0] obs;
        @(negedge clk);
        obs = {pc_write, ifid_write, idex_write, ifid_flush, idex_flush, exmem_flush,
               muldiv_start, muldiv_busy, halted};
        n_cmp++;
        assert (obs === exp_ctl) else begin
            n_err++;
            $error("FAIL %s[%0d] ctl got %b expected %b", tag, idx, obs, exp_ctl);
        end
        if (chk_st) begin
            n_cmp++;
            assert (state === exp_st) else begin
                n_err++;
                $error("FAIL %s[%0d] state got %b expected %b", tag, idx, state, exp_st);
            end
        end
    endtask

    initial begin
        // Reset for two cycles with a mul already sitting in EX.
        reset = 1'b1;
        drive(4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 1'b0);
        tick();
        check("rst", 0, C_RST, 2'b00, 1);
        tick();
        check("rst", 1, C_RST, 2'b00, 1);

        // Mul: start, 2 stall cycles in MULDIV, release, back to RUN.
        tick();
        reset = 1'b0;
        check("mul", 0, C_MDS, 2'b00, 1);
        tick(); check("mul", 1, C_MDB, 2'b01, 1);
        tick(); check("mul", 2, C_MDB, 2'b01, 1);
        tick(); check("mul", 3, C_REL, 2'b01, 1);
        tick(); nop(); check("mul", 4, C_DEF, 2'b00, 1);

        // Load-use hazards and non-hazards.
        tick(); drive(4'h0, 4'h3, 4'h0, 4'hA, 4'h0, 4'h3, 1'b0); check("lu_lw_rs", 0, C_BUB, 2'b00, 1);
        tick(); nop(); check("lu_after", 0, C_DEF, 2'b00, 1);
        tick(); drive(4'h0, 4'h4, 4'h5, 4'hA, 4'h0, 4'h3, 1'b0); check("lu_nomatch", 0, C_DEF, 2'b00, 1);
        tick(); drive(4'h0, 4'h1, 4'h5, 4'h8, 4'h0, 4'h5, 1'b0); check("lu_lbu_rt", 0, C_BUB, 2'b00, 1);
        tick(); drive(4'hC, 4'h3, 4'h0, 4'hA, 4'h0, 4'h3, 1'b0); check("lu_jmp", 0, C_JMP, 2'b00, 1);

        // Branch beats halt and jump in ID; jump alone flushes IF/ID only.
        tick(); drive(4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1); check("br_halt", 0, C_BR, 2'b00, 1);
        tick(); nop(); check("br_halt", 1, C_DEF, 2'b00, 1);
        tick(); drive(4'hC, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1); check("br_jmp", 0, C_BR, 2'b00, 1);
        tick(); drive(4'hC, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0); check("jmp", 0, C_JMP, 2'b00, 1);

        // Reset in MULDIV when cnt is 2 (third cycle of a mul).
        tick(); drive(4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 1'b0); check("mdrst", 0, C_MDS, 2'b00, 1);
        tick(); check("mdrst", 1, C_MDB, 2'b01, 1);
        tick(); reset = 1'b1; nop(); check("mdrst", 2, C_RST, 2'b00, 0);
        tick(); reset = 1'b0; check("mdrst", 3, C_DEF, 2'b00, 1);

        // Div with halt waiting in ID: 15 stall cycles, release, then halt takes over.
        tick(); drive(4'hF, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 1'b0); check("div", 0, C_MDS, 2'b00, 1);
        for (int i = 1; i <= 14; i++) begin
            tick(); check("div", i, C_MDB, 2'b01, 1);
        end
        tick(); check("div", 15, C_REL, 2'b01, 1);
        tick(); drive(4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0); check("halt_id", 0, C_BUB, 2'b00, 1);
        for (int i = 0; i < 3; i++) begin
            tick(); check("drain", i, C_BUB, 2'b10, 1);
        end
        for (int i = 0; i < 100; i++) begin
            tick(); check("halted", i, C_HALT, 2'b11, 1);
        end

        // Only reset leaves HALTED.
        tick(); reset = 1'b1; nop(); check("hrst", 0, C_RST, 2'b11, 0);
        tick(); check("hrst", 1, C_RST, 2'b00, 1);
        tick(); reset = 1'b0; check("hrst", 2, C_DEF, 2'b00, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
